regbank_intr_ctrl: RTL and testbench
====================================

Name: regbank_intr_ctrl

Overview:
- Interrupt sequencer for the 8-bit core: latches and prioritises external interrupt requests and takes them only at instruction boundaries.
- Drives the register-file bank select (`intr_en`), redirects the PC to the handler vector and returns to the saved PC on RETI.
- Sits between the interrupt sources, the fetch/PC unit and the register file.
- Single-level: no nesting.

Parameters:
- N_SRC, 4: number of interrupt request lines, 1..8.
- VEC_BASE, 8'hE0: handler address for source 0.
- VEC_STRIDE, 8'h08: address spacing between handler vectors.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- irq  in  N_SRC  interrupt request lines; rising edge sets pending bit.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  N_SRC  new mask value; 1 = source enabled.
- instr_done  in  1  one-cycle strobe: current instruction retires this cycle.
- reti  in  1  qualifies instr_done: retiring instruction is RETI.
- pc_next  in  8  PC of the instruction following the retiring one.
- intr_en  out  1  register-file bank select; 1 = interrupt bank.
- pc_load  out  1  one-cycle strobe: PC unit loads pc_load_addr.
- pc_load_addr  out  8  vector address or saved return PC.
- ack  out  N_SRC  one-hot pulse: source whose handler is being entered.
- pending  out  N_SRC  current pending bits, for status reads.
- mask  out  N_SRC  current mask register.

Behaviour:
- Async reset (reset_n=0), applied immediately:
  - state=IDLE; mask=0; pending=0; irq_q=0; epc=0; winner=0.
  - All outputs 0, including intr_en, pc_load, pc_load_addr and ack.
- All outputs are decoded from registered state only. There is no combinational input-to-output path.
- Edge detect:
  - Each cycle irq_q <= irq.
  - irq[i] & ~irq_q[i] sets pending[i].
  - A line held high through reset release records one edge on the first clock.
- Pending clear:
  - pending[i] clears in the ENTER cycle when winner=i.
  - If a new edge on i arrives in that same cycle, the set wins and pending[i] stays 1.
- Mask:
  - mask_we=1 loads mask_wdata at the clock edge.
  - The new value is used for arbitration from the next cycle.
  - Masked sources still accumulate pending bits.
- Arbitration: eligible = pending & mask. The lowest set index wins (fixed priority, source 0 highest).
- States:
  - IDLE:
    - intr_en=0.
    - If instr_done and eligible≠0: latch winner, epc<=pc_next, go ENTER.
    - Otherwise stay. reti in IDLE is ignored.
  - ENTER (exactly 1 cycle):
    - intr_en=1, pc_load=1, ack[winner]=1.
    - pc_load_addr = (VEC_BASE + winner*VEC_STRIDE) mod 256, 8-bit wrap.
    - Go ISR.
  - ISR:
    - intr_en=1.
    - New pending edges are latched but not taken (no nesting).
    - instr_done with reti=1: go EXIT. instr_done with reti=0: stay.
  - EXIT (exactly 1 cycle):
    - intr_en=0, pc_load=1, pc_load_addr=epc.
    - Go IDLE. No arbitration happens in this cycle.
- Latency:
  - Boundary strobe to pc_load: 1 cycle.
  - The earliest re-entry after EXIT is the next instr_done observed in IDLE. A source pending at RETI is therefore taken at the first boundary after return.
- The bank switch takes effect in the cycle after the deciding instr_done, so the retiring instruction writes the bank it started in.
- reset_n asserted mid-ISR:
  - Immediate return to IDLE with intr_en=0.
  - epc and pending are lost; no pc_load is issued.

Test Plan:
- Reset, mask=4'b0011, pulse irq[1], then instr_done with pc_next=8'h12 → next cycle: pc_load=1, pc_load_addr=8'hE8, ack=4'b0010, intr_en=1; pending[1]=0.
- irq[0] and irq[2] rise together, mask=4'b1111, instr_done → vector 8'hE0, ack=4'b0001. After RETI (epc return), pending[2] is still set and is taken at the next instr_done → pc_load_addr=8'hF0.
- In ISR, instr_done with reti=1 → EXIT: pc_load=1, pc_load_addr=saved 8'h12, intr_en=0; next cycle IDLE. A second irq edge during ISR causes no pc_load until after EXIT.
- mask=0, pulse irq[3] → pending=4'b1000, no entry on instr_done. Write mask=4'b1000 → entry at the next instr_done, vector 8'hF8.
- irq[1] edge coincident with the ENTER cycle for winner=1 → pending[1] remains 1 after ENTER.
- Assert reset_n=0 while in ISR → intr_en=0 and pending=0 immediately. reti alone in IDLE produces no pc_load.

Source files
------------

// File: rtl/regbank_intr_ctrl.sv
// Single-level interrupt sequencer: latches irq edges, arbitrates at instruction
// boundaries, switches the register bank and redirects the PC in and out of handlers.
module regbank_intr_ctrl #(
   parameter int         N_SRC      = 4,
   parameter logic [7:0] VEC_BASE   = 8'hE0,
   parameter logic [7:0] VEC_STRIDE = 8'h08
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [N_SRC-1:0] irq,
   input  logic             mask_we,
   input  logic [N_SRC-1:0] mask_wdata,
   input  logic             instr_done,
   input  logic             reti,
   input  logic [7:0]       pc_next,
   output logic             intr_en,
   output logic             pc_load,
   output logic [7:0]       pc_load_addr,
   output logic [N_SRC-1:0] ack,
   output logic [N_SRC-1:0] pending,
   output logic [N_SRC-1:0] mask
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ENTER = 2'd1;
   localparam logic [1:0] S_ISR   = 2'd2;
   localparam logic [1:0] S_EXIT  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [N_SRC-1:0] mask_q, mask_d;
   logic [N_SRC-1:0] pending_q, pending_d;
   logic [N_SRC-1:0] irq_q;
   logic [7:0]       epc_q, epc_d;
   logic [2:0]       winner_q, winner_d;

   logic [N_SRC-1:0] eligible;
   logic [N_SRC-1:0] enter_oh;
   logic [2:0]       pick;
   logic             found;
   logic [7:0]       vec;

   // Fixed priority: lowest enabled pending index wins.
   always_comb begin
      eligible = pending_q & mask_q;
      pick     = 3'd0;
      found    = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         if (!found && eligible[i]) begin
            pick  = 3'(i);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      enter_oh = '0;
      for (int i = 0; i < N_SRC; i++) begin
         enter_oh[i] = (state_q == S_ENTER) && (winner_q == 3'(i));
      end
   end

   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      epc_d    = epc_q;
      case (state_q)
         S_IDLE: begin
            if (instr_done && found) begin
               winner_d = pick;
               epc_d    = pc_next;
               state_d  = S_ENTER;
            end
         end
         S_ENTER: state_d = S_ISR;
         S_ISR: begin
            if (instr_done && reti) state_d = S_EXIT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A fresh edge in the ENTER cycle outranks the clear of the winner's bit.
   assign pending_d = (pending_q & ~enter_oh) | (irq & ~irq_q);
   assign mask_d    = mask_we ? mask_wdata : mask_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         mask_q    <= '0;
         pending_q <= '0;
         irq_q     <= '0;
         epc_q     <= 8'h00;
         winner_q  <= 3'd0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         pending_q <= pending_d;
         irq_q     <= irq;
         epc_q     <= epc_d;
         winner_q  <= winner_d;
      end
   end

   assign vec          = VEC_BASE + {5'd0, winner_q} * VEC_STRIDE;
   assign intr_en      = (state_q == S_ENTER) || (state_q == S_ISR);
   assign pc_load      = (state_q == S_ENTER) || (state_q == S_EXIT);
   assign pc_load_addr = (state_q == S_ENTER) ? vec :
                         (state_q == S_EXIT)  ? epc_q : 8'h00;
   assign ack          = enter_oh;
   assign pending      = pending_q;
   assign mask         = mask_q;

endmodule

// File: tb/tb_regbank_intr_ctrl.sv
// Bench for regbank_intr_ctrl: expected PC-load events are queued when the deciding
// boundary is driven and checked by a monitor whenever pc_load is seen.
module tb_regbank_intr_ctrl;

   localparam int N = 4;

   logic         clock;
   logic         reset_n;
   logic [N-1:0] irq;
   logic         mask_we;
   logic [N-1:0] mask_wdata;
   logic         instr_done;
   logic         reti;
   logic [7:0]   pc_next;
   logic         intr_en;
   logic         pc_load;
   logic [7:0]   pc_load_addr;
   logic [N-1:0] ack;
   logic [N-1:0] pending;
   logic [N-1:0] mask;

   typedef struct packed {
      logic [7:0]   addr;
      logic [N-1:0] ack;
      logic         ien;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;
   int  n_cmp = 0;
   int  n_bad = 0;

   regbank_intr_ctrl #(.N_SRC(N), .VEC_BASE(8'hE0), .VEC_STRIDE(8'h08)) dut (
      .clock(clock), .reset_n(reset_n), .irq(irq), .mask_we(mask_we),
      .mask_wdata(mask_wdata), .instr_done(instr_done), .reti(reti),
      .pc_next(pc_next), .intr_en(intr_en), .pc_load(pc_load),
      .pc_load_addr(pc_load_addr), .ack(ack), .pending(pending), .mask(mask)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Scoreboard monitor: every pc_load must match the oldest queued expectation.
   initial begin
      forever begin
         @(posedge clock);
         #2;
         if (pc_load === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_pc_load: got addr=%h ack=%b intr_en=%b, required no pc_load",
                        pc_load_addr, ack, intr_en);
            end else begin
               mon_e = exp_q.pop_front();
               if (pc_load_addr !== mon_e.addr || ack !== mon_e.ack || intr_en !== mon_e.ien) begin
                  n_bad++;
                  $display("FAIL pc_load_event: got addr=%h ack=%b intr_en=%b, required addr=%h ack=%b intr_en=%b",
                           pc_load_addr, ack, intr_en, mon_e.addr, mon_e.ack, mon_e.ien);
               end
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [7:0] a, input logic [N-1:0] k, input logic ien);
      ev_t e;
      e.addr = a;
      e.ack  = k;
      e.ien  = ien;
      exp_q.push_back(e);
   endtask

   task automatic write_mask(input logic [N-1:0] m);
      mask_we    = 1'b1;
      mask_wdata = m;
      cyc();
      mask_we    = 1'b0;
   endtask

   task automatic pulse_irq(input logic [N-1:0] lines);
      irq = lines;
      cyc();
      irq = '0;
      cyc();
   endtask

   task automatic boundary(input logic [7:0] pc, input logic r);
      instr_done = 1'b1;
      reti       = r;
      pc_next    = pc;
      cyc();
      instr_done = 1'b0;
      reti       = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #2;
      n_cmp++;
      if ({intr_en, pc_load, pc_load_addr, ack, pending, mask} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got intr_en=%b pc_load=%b addr=%h ack=%b pend=%b mask=%b, required all zero",
                  intr_en, pc_load, pc_load_addr, ack, pending, mask);
      end
      cyc();
      reset_n = 1'b1;
      cyc();
   endtask

   task automatic test_basic_entry();
      write_mask(4'b0011);
      n_cmp++;
      if (mask !== 4'b0011) begin
         n_bad++;
         $display("FAIL mask_write: got %b, required 0011", mask);
      end
      pulse_irq(4'b0010);
      n_cmp++;
      if (pending !== 4'b0010) begin
         n_bad++;
         $display("FAIL pending_set: got %b, required 0010", pending);
      end
      push(8'hE8, 4'b0010, 1'b1);
      boundary(8'h12, 1'b0);
      n_cmp++;
      if (pc_load !== 1'b1 || pc_load_addr !== 8'hE8 || intr_en !== 1'b1) begin
         n_bad++;
         $display("FAIL enter_src1: got pc_load=%b addr=%h intr_en=%b, required 1 E8 1",
                  pc_load, pc_load_addr, intr_en);
      end
      cyc();
      n_cmp++;
      if (pending !== 4'b0000 || intr_en !== 1'b1 || pc_load !== 1'b0) begin
         n_bad++;
         $display("FAIL isr_after_enter: got pend=%b intr_en=%b pc_load=%b, required 0000 1 0",
                  pending, intr_en, pc_load);
      end
   endtask

   task automatic test_exit_no_nest();
      pulse_irq(4'b0001);
      boundary(8'h33, 1'b0);
      n_cmp++;
      if (pc_load !== 1'b0 || intr_en !== 1'b1 || pending !== 4'b0001) begin
         n_bad++;
         $display("FAIL no_nesting: got pc_load=%b intr_en=%b pend=%b, required 0 1 0001",
                  pc_load, intr_en, pending);
      end
      push(8'h12, 4'b0000, 1'b0);
      boundary(8'h44, 1'b1);
      n_cmp++;
      if (pc_load !== 1'b1 || pc_load_addr !== 8'h12 || intr_en !== 1'b0) begin
         n_bad++;
         $display("FAIL exit_return: got pc_load=%b addr=%h intr_en=%b, required 1 12 0",
                  pc_load, pc_load_addr, intr_en);
      end
      cyc();
      n_cmp++;
      if (pc_load !== 1'b0 || intr_en !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_after_exit: got pc_load=%b intr_en=%b, required 0 0", pc_load, intr_en);
      end
      push(8'hE0, 4'b0001, 1'b1);
      boundary(8'h40, 1'b0);
      cyc();
      push(8'h40, 4'b0000, 1'b0);
      boundary(8'h41, 1'b1);
      cyc();
   endtask

   task automatic test_priority();
      write_mask(4'b1111);
      pulse_irq(4'b0101);
      push(8'hE0, 4'b0001, 1'b1);
      boundary(8'h50, 1'b0);
      cyc();
      push(8'h50, 4'b0000, 1'b0);
      boundary(8'h51, 1'b1);
      cyc();
      n_cmp++;
      if (pending !== 4'b0100) begin
         n_bad++;
         $display("FAIL pending_after_reti: got %b, required 0100", pending);
      end
      push(8'hF0, 4'b0100, 1'b1);
      boundary(8'h60, 1'b0);
      n_cmp++;
      if (pc_load_addr !== 8'hF0 || ack !== 4'b0100) begin
         n_bad++;
         $display("FAIL enter_src2: got addr=%h ack=%b, required F0 0100", pc_load_addr, ack);
      end
      cyc();
      push(8'h60, 4'b0000, 1'b0);
      boundary(8'h61, 1'b1);
      cyc();
   endtask

   task automatic test_masked();
      write_mask(4'b0000);
      pulse_irq(4'b1000);
      n_cmp++;
      if (pending !== 4'b1000) begin
         n_bad++;
         $display("FAIL masked_pending: got %b, required 1000", pending);
      end
      boundary(8'h70, 1'b0);
      n_cmp++;
      if (pc_load !== 1'b0 || intr_en !== 1'b0) begin
         n_bad++;
         $display("FAIL masked_no_entry: got pc_load=%b intr_en=%b, required 0 0", pc_load, intr_en);
      end
      write_mask(4'b1000);
      push(8'hF8, 4'b1000, 1'b1);
      boundary(8'h71, 1'b0);
      n_cmp++;
      if (pc_load_addr !== 8'hF8 || ack !== 4'b1000) begin
         n_bad++;
         $display("FAIL enter_src3: got addr=%h ack=%b, required F8 1000", pc_load_addr, ack);
      end
      cyc();
      push(8'h71, 4'b0000, 1'b0);
      boundary(8'h72, 1'b1);
      cyc();
   endtask

   task automatic test_coincident_edge();
      write_mask(4'b0010);
      pulse_irq(4'b0010);
      push(8'hE8, 4'b0010, 1'b1);
      boundary(8'h80, 1'b0);
      irq = 4'b0010;
      cyc();
      irq = 4'b0000;
      n_cmp++;
      if (pending !== 4'b0010) begin
         n_bad++;
         $display("FAIL set_wins_clear: got pend=%b, required 0010", pending);
      end
      push(8'h80, 4'b0000, 1'b0);
      boundary(8'h81, 1'b1);
      cyc();
      push(8'hE8, 4'b0010, 1'b1);
      boundary(8'h90, 1'b0);
      cyc();
      push(8'h90, 4'b0000, 1'b0);
      boundary(8'h91, 1'b1);
      cyc();
   endtask

   task automatic test_reset_mid_isr();
      write_mask(4'b0011);
      pulse_irq(4'b0001);
      push(8'hE0, 4'b0001, 1'b1);
      boundary(8'hA0, 1'b0);
      cyc();
      pulse_irq(4'b0010);
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (intr_en !== 1'b0 || pending !== 4'b0000 || pc_load !== 1'b0 || mask !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_mid_isr: got intr_en=%b pend=%b pc_load=%b mask=%b, required 0 0000 0 0000",
                  intr_en, pending, pc_load, mask);
      end
      cyc();
      reset_n = 1'b1;
      cyc();
      boundary(8'hB0, 1'b1);
      n_cmp++;
      if (pc_load !== 1'b0 || intr_en !== 1'b0) begin
         n_bad++;
         $display("FAIL reti_in_idle: got pc_load=%b intr_en=%b, required 0 0", pc_load, intr_en);
      end
      cyc();
   endtask

   task automatic test_drain();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d events outstanding, required 0", exp_q.size());
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      irq        = '0;
      mask_we    = 1'b0;
      mask_wdata = '0;
      instr_done = 1'b0;
      reti       = 1'b0;
      pc_next    = 8'h00;
      test_reset();
      test_basic_entry();
      test_exit_no_nest();
      test_priority();
      test_masked();
      test_coincident_edge();
      test_reset_mid_isr();
      test_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
